// File: rtl/stream_ctrl_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the HCI source streamer.
// slave is the arbiter's view; master is the requester/streamer side.
interface stream_ctrl_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CFG_W = 81
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0][CFG_W-1:0] req_cfg_i;
  logic [N_REQ-1:0]            req_grant_o;
  logic [N_REQ-1:0]            req_done_o;
  logic [CFG_W-1:0]            stream_ctrl_o;
  logic                        stream_ready_i;
  logic                        stream_done_i;

  modport slave (
    input  req_valid_i, req_cfg_i, stream_ready_i, stream_done_i,
    output req_grant_o, req_done_o, stream_ctrl_o
  );

  modport master (
    output req_valid_i, req_cfg_i, stream_ready_i, stream_done_i,
    input  req_grant_o, req_done_o, stream_ctrl_o
  );
endinterface

// File: rtl/stream_ctrl_arbiter.sv
// Round-robin arbiter sharing one HCI source streamer between N_REQ requesters,
// keeping exactly one transfer in flight and returning per-requester done pulses.
module stream_ctrl_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  stream_ctrl_arbiter_if.slave             arb_if,
  output logic                             busy_o,
  output logic [OW-1:0]                    owner_o,
  output logic [N_REQ-1:0][CNT_WIDTH-1:0]  done_cnt_o
);

  // req_start sits in the LSB so the requesters' flat descriptor maps onto this layout.
  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] tot_len;
    logic [15:0] d0_len;
    logic [15:0] d0_stride;
    logic        req_start;
  } hci_streamer_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  hci_streamer_ctrl_t              cfg_q, cfg_d;
  logic [OW-1:0]                   owner_q, owner_d;
  logic [OW-1:0]                   prio_q, prio_d;
  logic [N_REQ-1:0]                done_q, done_d;
  logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                            busy_q, busy_d;

  logic                            sel_found_s;
  logic [OW-1:0]                   sel_idx_s;
  logic [OW-1:0]                   nxt_prio_s;
  logic [N_REQ-1:0]                grant_s;

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return OW'(sum);
  endfunction

  // First pending request at or after prio_q, wrapping at N_REQ.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel_idx_s   = (!sel_found_s && arb_if.req_valid_i[wrap_idx(prio_q, k)])
                    ? wrap_idx(prio_q, k) : sel_idx_s;
      sel_found_s = sel_found_s | arb_if.req_valid_i[wrap_idx(prio_q, k)];
    end
  end

  assign nxt_prio_s = (sel_idx_s == OW'(N_REQ - 1)) ? '0 : sel_idx_s + OW'(1);

  // Zero-latency grant; masked while reset or clear is asserted.
  always_comb begin
    grant_s = '0;
    if ((state_q == ST_IDLE) && sel_found_s && rst_ni && !clear_i) begin
      grant_s[sel_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state and datapath updates for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          cfg_d           = hci_streamer_ctrl_t'(arb_if.req_cfg_i[sel_idx_s]);
          cfg_d.req_start = 1'b1;
          owner_d         = sel_idx_s;
          prio_d          = nxt_prio_s;
          state_d         = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (arb_if.stream_ready_i) begin
          cfg_d.req_start = 1'b0;
          state_d         = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (arb_if.stream_done_i) begin
          done_d[owner_q] = 1'b1;
          cnt_d[owner_q]  = cnt_q[owner_q] + CNT_WIDTH'(1);
          state_d         = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; clear_i behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      owner_q <= '0;
      prio_q  <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign arb_if.req_grant_o   = grant_s;
  assign arb_if.req_done_o    = done_q;
  assign arb_if.stream_ctrl_o = cfg_q;
  assign busy_o               = busy_q;
  assign owner_o              = owner_q;
  assign done_cnt_o           = cnt_q;

endmodule

// File: tb/tb_stream_ctrl_arbiter.sv
// Self-checking bench for stream_ctrl_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_stream_ctrl_arbiter;
  localparam int N_REQ     = 3;
  localparam int CNT_WIDTH = 16;
  localparam int CFG_W     = 81;
  localparam int OW        = 2;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic                            clear_i;
  logic                            busy_o;
  logic [OW-1:0]                   owner_o;
  logic [N_REQ-1:0][CNT_WIDTH-1:0] done_cnt_o;

  stream_ctrl_arbiter_if #(.N_REQ(N_REQ), .CFG_W(CFG_W)) bus ();

  stream_ctrl_arbiter #(.N_REQ(N_REQ), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .arb_if     (bus),
    .busy_o     (busy_o),
    .owner_o    (owner_o),
    .done_cnt_o (done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, its start status, RR pointer, counts.
  bit               m_active;
  bit               m_started;
  int               m_owner;
  int               m_prio;
  logic [CFG_W-1:0] m_cfg;
  int unsigned      m_cnt [N_REQ];
  logic [N_REQ-1:0] m_done;
  logic [N_REQ-1:0] last_grant;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(m_prio + k) % N_REQ]) return (m_prio + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [CFG_W-1:0] rand_cfg();
    return {$urandom(), $urandom(), 17'($urandom())};
  endfunction

  task automatic cyc(input logic rstn, input logic clr, input logic [N_REQ-1:0] valid,
                     input logic rdy, input logic dn);
    logic [N_REQ-1:0]            exp_g;
    logic [N_REQ-1:0][CFG_W-1:0] cfg_snap;
    int p;
    rst_ni             = rstn;
    clear_i            = clr;
    bus.req_valid_i    = valid;
    bus.stream_ready_i = rdy;
    bus.stream_done_i  = dn;
    #1;
    p     = pick(valid);
    exp_g = '0;
    if (rstn && !clr && !m_active && p >= 0) exp_g[p] = 1'b1;
    check_eq("grant", bus.req_grant_o, exp_g);
    last_grant = bus.req_grant_o;
    cfg_snap   = bus.req_cfg_i;
    @(posedge clk_i);
    #1;
    m_done = '0;
    if (!rstn || clr) begin
      m_active  = 1'b0;
      m_started = 1'b0;
      m_owner   = 0;
      m_prio    = 0;
      m_cfg     = '0;
      for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    end else if (!m_active) begin
      if (p >= 0) begin
        m_active  = 1'b1;
        m_started = 1'b0;
        m_owner   = p;
        m_prio    = (p + 1) % N_REQ;
        m_cfg     = cfg_snap[p];
        m_cfg[0]  = 1'b1;
      end
    end else if (!m_started) begin
      if (rdy) begin
        m_started = 1'b1;
        m_cfg[0]  = 1'b0;
      end
    end else if (dn) begin
      m_active        = 1'b0;
      m_done[m_owner] = 1'b1;
      m_cnt[m_owner]  = (m_cnt[m_owner] + 1) % 65536;
    end
    check_eq("stream_ctrl", bus.stream_ctrl_o, m_cfg);
    check_eq("req_done", bus.req_done_o, m_done);
    check_eq("busy", busy_o, m_active);
    check_eq("owner", owner_o, m_owner);
    for (int i = 0; i < N_REQ; i++)
      check_eq($sformatf("done_cnt%0d", i), done_cnt_o[i], m_cnt[i]);
  endtask

  initial begin
    int               rr_q [$];
    int               exp_rr [5];
    int               start_hi;
    int               extra_grants;
    int               stray_done;
    logic [N_REQ-1:0] rv;

    exp_rr = '{0, 1, 2, 0, 1};
    for (int i = 0; i < N_REQ; i++) bus.req_cfg_i[i] = rand_cfg();

    // Reset with all requests held: no grant while in reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b111, 1'b1, 1'b1);

    // Round-robin with immediate ready and done
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 3'b111, 1'b1, 1'b1);
      if (i == 0) check_eq("grant_after_reset", last_grant, 3'b001);
      if (last_grant != '0) rr_q.push_back(onehot_idx(last_grant));
    end
    check_eq("rr_count", rr_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("rr_order%0d", i), (i < rr_q.size()) ? rr_q[i] : 99, exp_rr[i]);

    // Single request from requester 1 after a clear
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    bus.req_cfg_i[1] = {32'h0000_0100, 16'd64, 16'd4, 16'd1, 1'b0};
    cyc(1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
    check_eq("single_grant", last_grant, 3'b010);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
    check_eq("single_done", bus.req_done_o, 3'b010);
    check_eq("single_cnt", done_cnt_o[1], 16'd1);

    // Backpressure: ready low for 5 cycles after the grant, others held valid
    start_hi     = 0;
    extra_grants = 0;
    cyc(1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    start_hi += int'(bus.stream_ctrl_o[0]);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 3'b101, (i == 5), 1'b0);
      start_hi += int'(bus.stream_ctrl_o[0]);
      if (last_grant != '0) extra_grants++;
    end
    check_eq("bp_start_cycles", start_hi, 6);
    check_eq("bp_extra_grants", extra_grants, 0);
    cyc(1'b1, 1'b0, 3'b101, 1'b0, 1'b1);
    check_eq("bp_done", bus.req_done_o, 3'b010);

    // Stray done pulses in IDLE, ISSUE and on the start-accept cycle
    stray_done = 0;
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    stray_done += int'(bus.req_done_o != '0);
    cyc(1'b1, 1'b0, 3'b001, 1'b0, 1'b1);
    stray_done += int'(bus.req_done_o != '0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    stray_done += int'(bus.req_done_o != '0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
    stray_done += int'(bus.req_done_o != '0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    stray_done += int'(bus.req_done_o != '0);
    check_eq("stray_done", stray_done, 0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    check_eq("post_stray_done", bus.req_done_o, 3'b001);

    // Clear while waiting for done
    cyc(1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b1);
    check_eq("clr_busy", busy_o, 1'b0);
    check_eq("clr_ctrl", bus.stream_ctrl_o, '0);
    check_eq("clr_cnt", done_cnt_o, '0);
    check_eq("clr_done", bus.req_done_o, 3'b000);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    check_eq("clr_late_done", bus.req_done_o, 3'b000);

    // Random traffic; requesters hold valid and descriptor until granted
    rv = '0;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!rv[i] && $urandom_range(2) == 0) begin
          rv[i]            = 1'b1;
          bus.req_cfg_i[i] = rand_cfg();
        end else if (rv[i] && $urandom_range(15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      cyc(($urandom_range(199) != 0), ($urandom_range(63) == 0), rv,
          ($urandom_range(1) == 1), ($urandom_range(2) == 0));
      rv &= ~last_grant;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_ctrl_arbiter.md
# stream_ctrl_arbiter

Shares one HCI source streamer between `N_REQ` requesters: the X-metadata loader, the X-data loader and the Y data scheduler. It accepts `hci_streamer_ctrl_t` descriptors over a valid/grant handshake and picks a requester round-robin. It drives the descriptor to the streamer with a `req_start` handshake, waits for completion, then returns a per-requester done pulse. It sits between the schedulers and the streamer `ctrl_i` port and guarantees that only one transfer is in flight at a time.

## Interface
- `N_REQ`, 3: number of requesters; must be at least 1.
- `CNT_WIDTH`, 16: width of each per-requester completed-transfer counter.

- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `clear_i`  in  1  synchronous soft clear; same effect as reset.
- `req_valid_i`  in  `N_REQ`  requester i has a descriptor pending.
- `req_cfg_i`  in  `N_REQ` x `hci_streamer_ctrl_t`  descriptor of each requester.
- `req_grant_o`  out  `N_REQ`  one-hot; descriptor i is accepted this cycle.
- `req_done_o`  out  `N_REQ`  one-cycle pulse when requester i's transfer completes.
- `stream_ctrl_o`  out  `hci_streamer_ctrl_t`  descriptor driven to the streamer.
- `stream_ready_i`  in  1  streamer can accept a start.
- `stream_done_i`  in  1  streamer finished the current transfer (pulse).
- `busy_o`  out  1  high whenever the state is not IDLE.
- `owner_o`  out  `max(1,$clog2(N_REQ))`  index of the current or last granted requester.
- `done_cnt_o`  out  `N_REQ` x `CNT_WIDTH`  completed-transfer count per requester.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT. Reset and `clear_i` force IDLE.
- **IDLE:** if any `req_valid_i` bit is set, grant the first set bit at or after `prio_q`, searching upward and wrapping at `N_REQ`.
  - The grant is combinational: `req_grant_o[i] = state==IDLE & req_valid_i[i] & selected(i)`.
  - It is forced to 0 while `rst_ni` is low or `clear_i` is high.
- **On grant:**
  - latch `req_cfg_i[i]` into `cfg_q`, with `req_start` forced to 1;
  - set `owner_q = i` and `prio_q = (i+1) mod N_REQ`;
  - go to ISSUE.
- **Requester duty:** hold `req_valid_i` and `req_cfg_i` stable until granted. Dropping valid before the grant withdraws the request with no side effects.
- **ISSUE:** `stream_ctrl_o = cfg_q` with `req_start = 1`. On the first cycle `stream_ready_i` is 1, clear `cfg_q.req_start` and go to WAIT.
- **WAIT:** `stream_ctrl_o` holds `cfg_q` with `req_start = 0`; the address generator fields stay stable. On `stream_done_i`:
  - register a pulse on `req_done_o[owner_q]`;
  - increment `done_cnt[owner_q]`, wrapping modulo 2^`CNT_WIDTH`;
  - go to IDLE.
- `stream_done_i` is ignored in IDLE and ISSUE. A done that arrives in the same cycle as the start acceptance is not counted.
- Only one grant can be active per transfer. No new grant is issued until the FSM is back in IDLE.
- With `N_REQ = 1`, `prio_q` stays at 0 and the block acts as a single-requester sequencer.
- **`clear_i` mid-transfer:** return to IDLE and zero `cfg_q`, `stream_ctrl_o`, counters, `prio_q` and `owner_q`. No done pulse is emitted. Draining the streamer is the top controller's responsibility.

## Timing
- **Reset values:**
  - `stream_ctrl_o = '0`, `req_grant_o = 0`, `req_done_o = 0`;
  - `busy_o = 0`, `owner_o = 0`, `done_cnt_o = 0`, `prio_q = 0`.
- **Grant latency:** 0 cycles. A valid request sampled in IDLE at cycle t is granted at cycle t.
- **Start:** `req_start` is high from t+1 and stays high through the cycle in which `stream_ready_i = 1` (cycle s, with s ≥ t+1). It is low from s+1.
- **Done:** `stream_done_i` at cycle d (d ≥ s+1) causes, at cycle d+1:
  - `req_done_o` pulses high for exactly one cycle;
  - the counter is updated;
  - the state is IDLE and `busy_o` is 0;
  - a new grant is possible in the same cycle.
- **Throughput:** minimum 3 cycles per transfer (grant, start, done) when the streamer responds immediately.
- All outputs except `req_grant_o` are registered.

## Test plan
- **Single request:** reset, then `req_valid_i = 3'b010`, `base_addr = 0x100`, `stream_ready_i = 1`.
  - Grant[1] at t, `req_start = 1` at t+1 only.
  - Done at t+4 gives `req_done_o = 3'b010` at t+5 and `done_cnt[1] = 1`.
- **Round-robin:** hold `req_valid_i = 3'b111` continuously with immediate ready/done. Required grant order: 0, 1, 2, 0, 1, and `owner_o` matches each grant.
- **Backpressure:** `stream_ready_i = 0` for 5 cycles after the grant.
  - `req_start` stays high for 6 cycles with a stable descriptor.
  - No second grant occurs while valid bits 0 and 2 are held high.
- **Stray done:** assert `stream_done_i` while in IDLE and while in ISSUE. Require no `req_done_o` pulse and no counter change.
- **Clear mid-transfer:** assert `clear_i` for 1 cycle in WAIT. Require:
  - next cycle `busy_o = 0`, `stream_ctrl_o = 0`, counters = 0, and no done pulse;
  - a later done is ignored.
- **Reset with valid held:** hold `rst_ni = 0` with `req_valid_i = 3'b111`. Require `req_grant_o = 0` throughout reset and grant[0] on the first cycle after release.
